// File: rtl/seg7_pkg.sv
// Shared types and the seven-segment decoder for the scanned counter display.
// Contents:
//   digit_t      - one BCD digit
//   SEG_0..SEG_9 - active-low segment patterns, bit order g..a
//   SEG_BLANK    - all segments off
//   seg7_decode  - BCD digit to segment pattern; codes 10..15 decode to blank
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_decode(input digit_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal (or base-6) counter digit with carry/borrow chaining.
// Ports:
//   clk_i    - clock
//   rst_ni   - synchronous reset, active-low
//   step_i   - count step for the whole chain this cycle
//   up_dn_i  - 1 = up, 0 = down
//   cin_i    - carry/borrow in from the next lower digit (tie 1 for digit 0)
//   clr_i    - synchronous clear, beats step
//   digit_o  - current digit value
//   cout_o   - carry/borrow out; digit is at its terminal value and is stepping
module bcd_digit
    import seg7_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   step_i,
    input  logic   up_dn_i,
    input  logic   cin_i,
    input  logic   clr_i,
    output digit_t digit_o,
    output logic   cout_o
);

    localparam digit_t MaxVal = digit_t'(MODULUS - 1);

    digit_t digit_q, digit_d;
    logic   advance;
    logic   at_term;

    assign advance = step_i & cin_i;
    assign at_term = up_dn_i ? (digit_q == MaxVal) : (digit_q == '0);
    assign cout_o  = advance & at_term;
    assign digit_o = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (advance) begin
            if (up_dn_i) begin
                digit_d = at_term ? '0 : digit_q + digit_t'(1);
            end else begin
                digit_d = at_term ? MaxVal : digit_q - digit_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit up/down counter driving a multiplexed common-anode 7-segment display.
// Ports:
//   clk_i       - system clock
//   rst_ni      - synchronous reset, active-low
//   en_i        - 1 = count on ticks, 0 = freeze count and tick divider
//   up_dn_i     - count direction, 1 = up
//   clr_i       - synchronous clear of digits and tick divider
//   cathode_o   - segments g..a, active-low
//   dp_o        - decimal point, active-low
//   anode_o     - digit select, one-hot-low
//   count_bcd_o - current digits, digit 0 in bits [3:0]
//   wrap_o      - one-cycle pulse after a full-range rollover
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int unsigned          NUM_DIGITS = 4,
    parameter int unsigned          TICK_DIV   = 50000000,
    parameter int unsigned          SCAN_DIV   = 125000,
    parameter logic [NUM_DIGITS-1:0] MOD6_MASK = 4'b1010,
    parameter logic [NUM_DIGITS-1:0] DP_MASK   = 4'b0100,
    parameter bit                   BLANK_LZ   = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      up_dn_i,
    input  logic                      clr_i,
    output logic [6:0]                cathode_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     anode_o,
    output logic [4*NUM_DIGITS-1:0]   count_bcd_o,
    output logic                      wrap_o
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned ScanW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW  = $clog2(NUM_DIGITS);

    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

    // Tick divider
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    assign tick = en_i && (tick_cnt_q == TickMax);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clr_i) begin
            tick_cnt_d = '0;
        end else if (en_i) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        end
    end

    // Digit chain; carry[i] enables digit i, carry[NUM_DIGITS] means full rollover
    digit_t              digits [NUM_DIGITS];
    logic [NUM_DIGITS:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit #(
            .MODULUS (MOD6_MASK[i] ? 6 : 10)
        ) u_digit (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .step_i  (tick),
            .up_dn_i (up_dn_i),
            .cin_i   (carry[i]),
            .clr_i   (clr_i),
            .digit_o (digits[i]),
            .cout_o  (carry[i+1])
        );
        assign count_bcd_o[4*i +: 4] = digits[i];
    end

    logic wrap_q, wrap_d;

    assign wrap_d = carry[NUM_DIGITS] & ~clr_i;

    // Scan divider and digit index, free-running
    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]  scan_idx_q, scan_idx_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + ScanW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == ScanMax) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IdxMax) ? '0 : scan_idx_q + IdxW'(1);
        end
    end

    // Segment selection; leading-zero blanking scans from the top digit down
    logic [6:0]            cathode_q, cathode_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] blank;
    digit_t                sel_digit;
    logic                  sel_blank;

    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (digits[i] == '0);
            blank[i]   = BLANK_LZ && (i != 0) && zero_above;
        end

        sel_digit = '0;
        sel_blank = 1'b0;
        dp_d      = 1'b1;
        anode_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IdxW'(i)) begin
                sel_digit  = digits[i];
                sel_blank  = blank[i];
                dp_d       = ~DP_MASK[i];
                anode_d[i] = 1'b0;
            end
        end
        cathode_d = sel_blank ? SEG_BLANK : seg7_decode(sel_digit);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            wrap_q     <= 1'b0;
            cathode_q  <= SEG_BLANK;
            dp_q       <= 1'b1;
            anode_q    <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            wrap_q     <= wrap_d;
            cathode_q  <= cathode_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
        end
    end

    assign cathode_o = cathode_q;
    assign dp_o      = dp_q;
    assign anode_o   = anode_q;
    assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
module tb_seg7_scan_counter;

    localparam int unsigned ND = 4;
    localparam int unsigned TD = 4;
    localparam int unsigned SD = 3;
    localparam logic [3:0]  M6 = 4'b1010;
    localparam logic [3:0]  DPM = 4'b0100;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        up_dn_i = 1'b1;
    logic        clr_i = 1'b0;
    logic [6:0]  cathode_o;
    logic        dp_o;
    logic [3:0]  anode_o;
    logic [15:0] count_bcd_o;
    logic        wrap_o;

    seg7_scan_counter #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .SCAN_DIV   (SD),
        .MOD6_MASK  (M6),
        .DP_MASK    (DPM),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .up_dn_i     (up_dn_i),
        .clr_i       (clr_i),
        .cathode_o   (cathode_o),
        .dp_o        (dp_o),
        .anode_o     (anode_o),
        .count_bcd_o (count_bcd_o),
        .wrap_o      (wrap_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: the count is a single integer in mixed radix
    function automatic int dig_mod(input int i);
        return M6[i] ? 6 : 10;
    endfunction

    function automatic int weight(input int i);
        int w = 1;
        for (int k = 0; k < i; k++) w *= dig_mod(k);
        return w;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / weight(i)) % dig_mod(i));
        return r;
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    typedef struct packed {
        logic [15:0] cnt;
        logic        wrap;
        logic [6:0]  cath;
        logic        dp;
        logic [3:0]  an;
    } exp_t;

    exp_t sb_q[$];

    int mdl_val  = 0;
    int mdl_ecnt = 0;
    int mdl_scyc = 0;

    always @(posedge clk_i) begin : model
        exp_t e;
        int   idx;
        int   range_v;
        logic tk;
        range_v = weight(ND);
        if (!rst_ni) begin
            mdl_val  = 0;
            mdl_ecnt = 0;
            mdl_scyc = 0;
            e.cnt  = 16'h0000;
            e.wrap = 1'b0;
            e.cath = 7'h7F;
            e.dp   = 1'b1;
            e.an   = 4'hF;
        end else begin
            idx = (mdl_scyc / SD) % ND;
            if (idx > 0 && mdl_val < weight(idx)) e.cath = 7'h7F;
            else e.cath = ref_seg((mdl_val / weight(idx)) % dig_mod(idx));
            e.dp = ~DPM[idx];
            e.an = ~(4'b0001 << idx);
            mdl_scyc++;
            tk = en_i && ((mdl_ecnt % TD) == TD - 1);
            e.wrap = 1'b0;
            if (clr_i) begin
                mdl_val  = 0;
                mdl_ecnt = 0;
            end else begin
                if (en_i) mdl_ecnt++;
                if (tk) begin
                    if (up_dn_i) begin
                        e.wrap  = (mdl_val == range_v - 1);
                        mdl_val = (mdl_val + 1) % range_v;
                    end else begin
                        e.wrap  = (mdl_val == 0);
                        mdl_val = (mdl_val + range_v - 1) % range_v;
                    end
                end
            end
            e.cnt = to_bcd(mdl_val);
        end
        sb_q.push_back(e);
    end

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("count_bcd", 32'(count_bcd_o), 32'(e.cnt));
            chk("wrap", 32'(wrap_o), 32'(e.wrap));
            chk("cathode", 32'(cathode_o), 32'(e.cath));
            chk("dp", 32'(dp_o), 32'(e.dp));
            chk("anode", 32'(anode_o), 32'(e.an));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        cyc(2);
        rst_ni  = 1'b1;
        en_i    = 1'b1;
        up_dn_i = 1'b1;
        cyc(40);
        @(negedge clk_i);
        chk("ten_ticks", 32'(count_bcd_o), 32'h0010);

        // Walk up to 09:59, then ripple through the mod-6 digit
        cyc(589 * 4);
        @(negedge clk_i);
        chk("preload_0959", 32'(count_bcd_o), 32'h0959);
        cyc(4);
        @(negedge clk_i);
        chk("ripple_1000", 32'(count_bcd_o), 32'h1000);
        chk("ripple_no_wrap", 32'(wrap_o), 32'h0);

        // Down from zero wraps to all-max, then up wraps back
        clr_i = 1'b1;
        cyc(1);
        clr_i   = 1'b0;
        up_dn_i = 1'b0;
        cyc(4);
        @(negedge clk_i);
        chk("down_wrap_cnt", 32'(count_bcd_o), 32'h5959);
        chk("down_wrap_pulse", 32'(wrap_o), 32'h1);
        up_dn_i = 1'b1;
        cyc(4);
        @(negedge clk_i);
        chk("up_wrap_cnt", 32'(count_bcd_o), 32'h0000);
        chk("up_wrap_pulse", 32'(wrap_o), 32'h1);

        // Freeze, then reset mid-count
        en_i = 1'b0;
        cyc(20);
        en_i = 1'b1;
        cyc(6);
        rst_ni = 1'b0;
        cyc(1);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_count", 32'(count_bcd_o), 32'h0000);
        chk("rst_anode", 32'(anode_o), 32'hF);
        chk("rst_cathode", 32'(cathode_o), 32'h7F);

        // Randomised phase
        for (int i = 0; i < 2000; i++) begin
            en_i    = ($urandom_range(0, 7) != 0);
            up_dn_i = ($urandom_range(0, 15) < 10);
            clr_i   = ($urandom_range(0, 31) == 0);
            rst_ni  = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_ni = 1'b1;
        clr_i  = 1'b0;
        cyc(2);
        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
- Parametrised multi-digit decimal up/down counter with a multiplexed seven-segment driver. It generalises the fixed two-digit seconds display.
- Digit count, per-digit modulus (10 or 6), tick rate and scan rate are parameters. It adds enable, direction, clear, leading-zero blanking, decimal points and a wrap pulse.
- It sits at the top of the board I/O path and drives the common-anode 4-digit display directly.

Parameters:
- NUM_DIGITS, 4, number of digits; range 2..8.
- TICK_DIV, 50000000, clk cycles per count step (1 Hz at 50 MHz); must be at least 2.
- SCAN_DIV, 125000, clk cycles per digit scan slot; must be at least 2.
- MOD6_MASK, 4'b1010, bit i=1 makes digit i count modulo 6, otherwise modulo 10. The default gives MM:SS.
- DP_MASK, 4'b0100, bit i=1 lights the decimal point while digit i is selected.
- BLANK_LZ, 1, 1 = blank leading zeros above digit 0.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active-low
- en  in  1  1 = count on ticks; 0 = freeze count and tick divider
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle
- clr  in  1  synchronous clear of digits and tick divider
- cathode  out  7  segments g..a, active-low
- dp  out  1  decimal point, active-low
- anode  out  NUM_DIGITS  digit select, active-low, one-hot-low
- count_bcd  out  4*NUM_DIGITS  current digits, digit 0 in bits [3:0]
- wrap  out  1  one-cycle pulse on full-range rollover

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - all digits to 0, tick divider to 0, scan divider to 0, scan index to 0;
  - cathode=7'h7F, dp=1, anode all 1s, wrap=0.
- Tick divider:
  - Counts 0..TICK_DIV-1 while en=1.
  - tick is high for the one cycle the divider equals TICK_DIV-1; the divider then returns to 0.
  - With en=0 the divider holds its value.
- Count step on tick (en=1, clr=0):
  - Digit 0 steps by one. Carry/borrow ripples combinationally, so all digits update on the same edge.
  - Digit i wraps at 5 or 9 per MOD6_MASK.
  - Up at all-max gives all 0s. Down at all-0s gives all-max.
  - wrap=1 in the cycle following that edge only.
- clr has priority over tick:
  - Digits go to 0 and the divider goes to 0 on the next edge.
  - No wrap pulse.
  - The scan logic is unaffected.
- Scan logic:
  - The scan divider runs continuously, independent of en and clr.
  - At SCAN_DIV-1 the scan index advances 0..NUM_DIGITS-1 and wraps to 0.
- Output registration:
  - cathode, dp and anode are registered from the current index and digits, with one-cycle latency.
  - A digit change appears on the segments by the next clk, without waiting for a scan slot.
- Decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 decode to 7'h7F; they are unreachable.
- Blanking: with BLANK_LZ=1, digit i>0 shows 7'h7F when it and all higher digits are 0. Digit 0 is never blanked. The anode is still driven for blanked digits.
- dp = ~DP_MASK[index], registered with cathode.
- Simultaneous events: clr+tick means clr wins. A tick on the same edge as a scan advance has both take effect.
- rst_n mid-count returns everything to the reset state on that edge.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the function seg7_decode(4-bit) returning 7 bits;
  - the digit-type typedef (logic [3:0]).
- Sub-module bcd_digit is instantiated NUM_DIGITS times. It takes a modulus parameter, inputs step, up_dn, cin and clr, and outputs digit and cout.
  - cout is high when step is high, cin is high, and the digit is at its terminal value for the current direction.
  - A digit steps only when step and cin are both high; digit 0 has cin tied to 1.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=3, MOD6_MASK=4'b1010, BLANK_LZ=1, DP_MASK=4'b0100):
- Reset then en=1, up_dn=1 for 10 ticks (40 clks) -> count_bcd=16'h0010; digit 0 shows 1000000; digit 1 shows 1111001; digits 2,3 blanked 7'h7F.
- From preload count 16'h0959 (via prior stepping), one tick -> 16'h1000; ripple through a mod-6 digit; no wrap.
- At 16'h5959 up, one tick -> 16'h0000 and wrap high exactly 1 cycle. At 16'h0000 down, one tick -> 16'h5959 and wrap high exactly 1 cycle.
- Scan: anode sequence 1110,1101,1011,0111 repeating, each held 3 clks. dp=0 only while anode=1011.
- clr asserted on a tick cycle -> 16'h0000, wrap stays 0; en=0 for 20 clks -> count and divider frozen, anode still scanning.
- rst_n=0 for one edge mid-count -> all outputs to reset values on that edge; counting resumes from 0 after TICK_DIV clks.
